ysyx_24090003_mem_arbiter: RTL and testbench

Shares the CPU's single memory port between instruction fetch (IFU) and load/store (LSU) once the core becomes multi-cycle. It accepts one request at a time, picks a winner with round-robin arbitration, and drives a registered request onto the memory bus. It then waits for the memory response and routes it back to the requester that owns the transaction. The block sits between the IFU/LSU and the top-level memory ports.

---
 rtl/ysyx_24090003_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_ysyx_24090003_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_mem_arbiter.sv
// rtl/ysyx_24090003_mem_arbiter.sv - round-robin IFU/LSU arbiter for the single memory port
//
// Purpose:
//   Shares one memory port between instruction fetch (IFU) and load/store (LSU).
//   One transaction is outstanding at a time: IDLE -> REQ -> RESP -> IDLE.
//   The request payload is captured at grant time and driven from registers.
//   The response is steered back to whichever requester owns the transaction.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_if_req/i_if_addr                 IFU request (held until o_if_gnt)
//   o_if_gnt/o_if_rvalid/o_if_rdata    IFU grant and fetch response
//   i_ls_req/addr/wdata/we/wmask       LSU request (held until o_ls_gnt)
//   o_ls_gnt/o_ls_rvalid/o_ls_rdata    LSU grant and load/store response
//   o_mem_en/we/addr/wdata/wmask       registered request to memory
//   i_mem_ready                        memory accepts the request
//   i_mem_rvalid/i_mem_rdata           memory response
//   o_busy                             a transaction is in flight

module ysyx_24090003_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  input  logic          i_ls_we,
  input  logic [2:0]    i_ls_wmask,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [2:0]    o_mem_wmask,
  input  logic          i_mem_ready,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            last_ls;   // 1 = LSU won the most recent grant
  logic            owner_ls;  // 1 = LSU owns the in-flight transaction
  logic            mem_en_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [2:0]      wmask_q;

  logic            idle_ok;
  logic            if_gnt;
  logic            ls_gnt;
  logic            resp_fire;

  // Grants are suppressed during reset so nothing is accepted in a reset cycle.
  assign idle_ok = (state == IDLE) && !i_rst;

  // On a tie the side that did not win last time is granted.
  assign ls_gnt = idle_ok && i_ls_req && (!i_if_req || !last_ls);
  assign if_gnt = idle_ok && i_if_req && (!i_ls_req || last_ls);

  // Responses only count in RESP; anything seen in IDLE or REQ is dropped.
  assign resp_fire = !i_rst && (state == RESP) && i_mem_rvalid;

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_if_rvalid = resp_fire && !owner_ls;
  assign o_ls_rvalid = resp_fire && owner_ls;
  assign o_if_rdata  = i_mem_rdata;
  assign o_ls_rdata  = i_mem_rdata;

  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_busy      = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      last_ls  <= 1'b0;
      owner_ls <= 1'b0;
      mem_en_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (ls_gnt) begin
            addr_q   <= i_ls_addr;
            wdata_q  <= i_ls_wdata;
            we_q     <= i_ls_we;
            wmask_q  <= i_ls_wmask;
            owner_ls <= 1'b1;
            last_ls  <= 1'b1;
            mem_en_q <= 1'b1;
            state    <= REQ;
          end else if (if_gnt) begin
            // Fetches are always word reads.
            addr_q   <= i_if_addr;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            wmask_q  <= 3'b010;
            owner_ls <= 1'b0;
            last_ls  <= 1'b0;
            mem_en_q <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // Payload stays put; only the enable drops once memory accepts.
          if (i_mem_ready) begin
            mem_en_q <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          mem_en_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_mem_arbiter.sv
// tb/tb_ysyx_24090003_mem_arbiter.sv - scoreboard bench for the IFU/LSU memory arbiter

module tb_ysyx_24090003_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_we = 1'b0;
  logic [2:0]  ls_wmask = 3'b000;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  ysyx_24090003_mem_arbiter #(.AW(32), .DW(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_ls_req(ls_req), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
    .i_ls_we(ls_we), .i_ls_wmask(ls_wmask),
    .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_busy(busy)
  );

  typedef struct {
    bit          ls;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  wmask;
  } bus_t;

  bit    gnt_q[$];
  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    tests = 0;
  int    fails = 0;

  // Memory model controls, written only by the stimulus process.
  int ready_stall = 0;
  int rv_stall = 0;
  bit rv_with_ready = 1'b0;
  bit stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic expect_txn(input bit ls, input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic [2:0] wm);
    bus_t  b;
    resp_t r;
    gnt_q.push_back(ls);
    b.addr  = a;
    b.wdata = ls ? wd : 32'h0;
    b.we    = ls ? we : 1'b0;
    b.wmask = ls ? wm : 3'b010;
    bus_q.push_back(b);
    r.ls   = ls;
    r.data = mem_f(a);
    resp_q.push_back(r);
  endtask

  // Memory responder: acts just after each rising edge on the new state.
  int rcnt = 0;
  int vcnt = 0;
  always @(posedge clk) begin
    #1;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hCAFE_F00D;
    if (mem_en) begin
      vcnt = 0;
      if (rcnt >= ready_stall) begin
        mem_ready = 1'b1;
        rcnt = 0;
        if (rv_with_ready) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0_BAD0;
        end
      end else begin
        rcnt++;
      end
    end else if (busy) begin
      rcnt = 0;
      if (vcnt >= rv_stall) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_f(mem_addr);
        vcnt = 0;
      end else begin
        vcnt++;
      end
    end else begin
      rcnt = 0;
      vcnt = 0;
      if (stray_en) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant, bus beat or response.
  always @(negedge clk) begin
    bit    eg;
    bus_t  b;
    resp_t r;
    if (if_gnt && ls_gnt) begin
      chk("dual_gnt", 32'(if_gnt & ls_gnt), 32'd0);
    end else if (if_gnt || ls_gnt) begin
      if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(ls_gnt), 32'(if_gnt));
      else begin
        eg = gnt_q.pop_front();
        chk("gnt_owner_ls", 32'(ls_gnt), 32'(eg));
      end
    end
    if (mem_en) begin
      if (bus_q.size() == 0) chk("mem_en_unexpected", 32'(mem_en), 32'd0);
      else begin
        b = bus_q[0];
        chk("bus_addr", mem_addr, b.addr);
        chk("bus_wdata", mem_wdata, b.wdata);
        chk("bus_we", 32'(mem_we), 32'(b.we));
        chk("bus_wmask", 32'(mem_wmask), 32'(b.wmask));
        if (mem_ready) void'(bus_q.pop_front());
      end
    end
    if (if_rvalid && ls_rvalid) begin
      chk("dual_rvalid", 32'(if_rvalid & ls_rvalid), 32'd0);
    end else if (if_rvalid || ls_rvalid) begin
      if (resp_q.size() == 0) chk("rvalid_unexpected", 32'(if_rvalid | ls_rvalid), 32'd0);
      else begin
        r = resp_q.pop_front();
        chk("rvalid_owner_ls", 32'(ls_rvalid), 32'(r.ls));
        chk("rdata", ls_rvalid ? ls_rdata : if_rdata, r.data);
      end
    end
  end

  task automatic wait_gnt(input bit ls, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = ls ? ls_gnt : if_gnt;
    end
    if (!seen) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int gcount;
    int busy_cnt;
    int en_cnt;
    int rv_cnt;
    int n;

    // Reset with both requesters active: nothing may be granted.
    if_req   = 1'b1; if_addr  = 32'h8000_0100;
    ls_req   = 1'b1; ls_addr  = 32'h8000_2000;
    ls_wdata = 32'h1122_3344; ls_we = 1'b0; ls_wmask = 3'b010;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 32'({if_gnt, ls_gnt}), 32'd0);
      chk("rst_ctrl", 32'({mem_en, mem_we, mem_wmask, busy}), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    end
    // First tie after reset goes to LSU, then IFU gets the next idle slot.
    expect_txn(1'b1, 32'h8000_2000, 32'h1122_3344, 1'b0, 3'b010);
    expect_txn(1'b0, 32'h8000_0100, 32'h0, 1'b0, 3'b010);
    @(posedge clk); #1 rst = 1'b0;
    wait_gnt(1'b1, "rst_first");
    @(posedge clk); #1 ls_req = 1'b0;
    wait_gnt(1'b0, "rst_second");
    @(posedge clk); #1 if_req = 1'b0;
    wait_idle("rst_seq");

    // Continuous contention: grants alternate starting with LSU.
    if_addr = 32'h8000_0200;
    ls_addr = 32'h8000_3000; ls_wdata = 32'h55AA_55AA; ls_we = 1'b0; ls_wmask = 3'b100;
    for (int k = 0; k < 4; k++)
      expect_txn((k % 2) == 0, (k % 2) == 0 ? 32'h8000_3000 : 32'h8000_0200,
                 32'h55AA_55AA, 1'b0, 3'b100);
    @(posedge clk); #1 if_req = 1'b1; ls_req = 1'b1;
    gcount = 0;
    n = 0;
    while (gcount < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (if_gnt || ls_gnt) gcount++;
    end
    chk("contention_gnt_count", 32'(gcount), 32'd4);
    @(posedge clk); #1 if_req = 1'b0; ls_req = 1'b0;
    wait_idle("contention");

    // Single fetch with minimum latency.
    expect_txn(1'b0, 32'h8000_0000, 32'h0, 1'b0, 3'b010);
    @(posedge clk); #1 if_addr = 32'h8000_0000; if_req = 1'b1;
    @(negedge clk);
    chk("fetch_c0_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); #1 if_req = 1'b0; if_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("fetch_c1_en", 32'(mem_en), 32'd1);
    chk("fetch_c1_addr", mem_addr, 32'h8000_0000);
    chk("fetch_c1_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("fetch_c2_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_c2_if_rdata", if_rdata, 32'h0010_0073);
    chk("fetch_c2_ls_rvalid", 32'(ls_rvalid), 32'd0);
    @(negedge clk);
    chk("fetch_c3_idle", 32'(busy), 32'd0);

    // Store with 3 ready stalls and one rvalid stall (response in the 2nd RESP cycle).
    ready_stall = 3;
    rv_stall    = 1;
    expect_txn(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 3'b001);
    @(posedge clk); #1;
    ls_addr = 32'h8000_1000; ls_wdata = 32'hDEAD_BEEF; ls_we = 1'b1; ls_wmask = 3'b001;
    ls_req = 1'b1;
    @(negedge clk);
    chk("store_gnt", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1 ls_req = 1'b0; ls_wdata = 32'h0; ls_addr = 32'h0; ls_we = 1'b0;
    busy_cnt = 0; en_cnt = 0; rv_cnt = 0;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      busy_cnt++;
      if (mem_en) en_cnt++;
      if (ls_rvalid) rv_cnt++;
      n++;
      @(negedge clk);
    end
    chk("store_busy_cycles", 32'(busy_cnt), 32'd6);
    chk("store_req_cycles", 32'(en_cnt), 32'd4);
    chk("store_rvalid_pulses", 32'(rv_cnt), 32'd1);
    ready_stall = 0;
    rv_stall    = 0;

    // Stray rvalid while idle must not produce a response.
    stray_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
    end
    stray_en = 1'b0;
    @(negedge clk);

    // ready and rvalid together in REQ: the rvalid is dropped.
    rv_with_ready = 1'b1;
    rv_stall      = 2;
    expect_txn(1'b0, 32'h8000_0300, 32'h0, 1'b0, 3'b010);
    @(posedge clk); #1 if_addr = 32'h8000_0300; if_req = 1'b1;
    wait_gnt(1'b0, "rr");
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    chk("rr_ready_seen", 32'({mem_en, mem_ready, mem_rvalid}), 32'h7);
    chk("rr_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    @(negedge clk);
    chk("rr_waits_in_resp", 32'({busy, mem_en}), 32'h2);
    wait_idle("rr");
    rv_with_ready = 1'b0;
    rv_stall      = 0;

    // LSU request raised mid-transaction is granted in the first idle cycle.
    ready_stall = 2;
    expect_txn(1'b0, 32'h8000_0400, 32'h0, 1'b0, 3'b010);
    expect_txn(1'b1, 32'h8000_4000, 32'h7777_8888, 1'b0, 3'b010);
    @(posedge clk); #1 if_addr = 32'h8000_0400; if_req = 1'b1;
    wait_gnt(1'b0, "mid_if");
    @(posedge clk); #1;
    if_req = 1'b0;
    ls_addr = 32'h8000_4000; ls_wdata = 32'h7777_8888; ls_we = 1'b0; ls_wmask = 3'b010;
    ls_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!if_rvalid && n < 50) begin
      chk("mid_no_gnt_busy", 32'(ls_gnt), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("mid_if_rvalid", 32'(if_rvalid), 32'd1);
    @(negedge clk);
    chk("mid_gnt_first_idle", 32'(ls_gnt), 32'd1);
    @(posedge clk); #1 ls_req = 1'b0;
    wait_idle("mid");
    ready_stall = 0;

    // Reset while waiting in RESP abandons the transaction.
    rv_stall = 10;
    expect_txn(1'b0, 32'h8000_0500, 32'h0, 1'b0, 3'b010);
    @(posedge clk); #1 if_addr = 32'h8000_0500; if_req = 1'b1;
    wait_gnt(1'b0, "rstresp");
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstresp_in_resp", 32'({busy, mem_en}), 32'h2);
    @(posedge clk); #1 rst = 1'b1;
    if (resp_q.size() > 0) void'(resp_q.pop_back());
    @(negedge clk);
    chk("rstresp_no_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rv_stall = 0;
    @(negedge clk);
    chk("rstresp_idle", 32'(busy), 32'd0);
    chk("rstresp_addr_clr", mem_addr, 32'd0);
    chk("rstresp_no_rvalid2", 32'({if_rvalid, ls_rvalid}), 32'd0);

    // A later store completes normally.
    expect_txn(1'b1, 32'h8000_5000, 32'hA5A5_0001, 1'b1, 3'b010);
    @(posedge clk); #1;
    ls_addr = 32'h8000_5000; ls_wdata = 32'hA5A5_0001; ls_we = 1'b1; ls_wmask = 3'b010;
    ls_req = 1'b1;
    wait_gnt(1'b1, "post_rst");
    @(posedge clk); #1 ls_req = 1'b0;
    wait_idle("post_rst");
    repeat (2) @(negedge clk);

    chk("queues_empty", 32'(gnt_q.size() + resp_q.size() + bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

endmodule
